// File: rtl/f2i_top_if.sv
// Internal byte-wide memory bus between the converter FSM and its data memory.
// Combinational read of addr onto rdata; write of wdata to addr on the clock edge while we is high.
interface f2i_top_if;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;

    modport master (output we, output addr, output wdata, input rdata);
    modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/f2i_top.sv
// Converts a binary16 operand held in data memory into a sign-magnitude int16 result in the same memory.
// Optional ROUND_NEAREST_EN: round half-up on the first discarded bit instead of truncating.
module f2i_data_mem #(
    parameter int MEM_DEPTH = 256
) (
    input logic      clk,
    f2i_top_if.slave bus
);
    // Not reset: contents persist across resets and are loaded by backdoor.
    logic [7:0] my_memory [0:MEM_DEPTH-1];

    always_ff @(posedge clk) begin
        if (bus.we) my_memory[bus.addr] <= bus.wdata;
    end

    assign bus.rdata = my_memory[bus.addr];
endmodule

module f2i_top #(
    parameter logic [7:0] OP_ADDR   = 8'd64,
    parameter logic [7:0] RES_ADDR  = 8'd66,
    parameter int         MEM_DEPTH = 256
) (
    input  logic       clk_i,
    input  logic       reset_i,
    output logic       done_o,
    output logic [2:0] fsm_state
);
`ifdef ROUND_NEAREST_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE, LD_HI, LD_LO, DECODE, SHIFT, ST_HI, ST_LO, DONE
    } state_t;

    state_t      state;
    logic [15:0] flt;
    logic        sign;
    logic [14:0] mag;
    logic [3:0]  sh_cnt;
    logic        sh_left;
    logic        guard;

    logic signed [5:0] dec_exp;
    logic [10:0]       dec_mant;

    f2i_top_if mem_bus ();

    f2i_data_mem #(.MEM_DEPTH(MEM_DEPTH)) data_mem1 (
        .clk (clk_i),
        .bus (mem_bus.slave)
    );

    assign dec_exp   = $signed({1'b0, flt[14:10]}) - 6'sd15;
    assign dec_mant  = {|flt[14:10], flt[9:0]};
    assign fsm_state = state;

    always_comb begin
        mem_bus.we    = 1'b0;
        mem_bus.addr  = OP_ADDR;
        mem_bus.wdata = 8'd0;
        case (state)
            LD_LO: mem_bus.addr = OP_ADDR + 8'd1;
            ST_HI: begin
                mem_bus.we    = 1'b1;
                mem_bus.addr  = RES_ADDR;
                mem_bus.wdata = {sign, mag[14:8]};
            end
            ST_LO: begin
                mem_bus.we    = 1'b1;
                mem_bus.addr  = RES_ADDR + 8'd1;
                mem_bus.wdata = mag[7:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state   <= IDLE;
            done_o  <= 1'b0;
            flt     <= 16'd0;
            sign    <= 1'b0;
            mag     <= 15'd0;
            sh_cnt  <= 4'd0;
            sh_left <= 1'b0;
            guard   <= 1'b0;
        end else begin
            case (state)
                IDLE:  state <= LD_HI;
                LD_HI: begin
                    flt[15:8] <= mem_bus.rdata;
                    state     <= LD_LO;
                end
                LD_LO: begin
                    flt[7:0] <= mem_bus.rdata;
                    state    <= DECODE;
                end
                DECODE: begin
                    sign    <= flt[15];
                    guard   <= 1'b0;
                    sh_left <= 1'b0;
                    sh_cnt  <= 4'd0;
                    // Out-of-range exponents skip shifting; e == -1 leaves a half to round.
                    if (dec_exp > 6'sd14) begin
                        mag <= 15'h7FFF;
                    end else if (dec_exp < 6'sd0) begin
                        mag   <= 15'd0;
                        guard <= (dec_exp == -6'sd1);
                    end else if (dec_exp >= 6'sd10) begin
                        mag     <= {4'd0, dec_mant};
                        sh_left <= 1'b1;
                        sh_cnt  <= 4'(dec_exp - 6'sd10);
                    end else begin
                        mag    <= {4'd0, dec_mant};
                        sh_cnt <= 4'(6'sd10 - dec_exp);
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    if (sh_cnt != 4'd0) begin
                        sh_cnt <= sh_cnt - 4'd1;
                        if (sh_left) begin
                            mag <= {mag[13:0], 1'b0};
                        end else begin
                            guard <= mag[0];
                            mag   <= {1'b0, mag[14:1]};
                        end
                    end else begin
                        if (ROUND_EN && guard && (mag != 15'h7FFF)) mag <= mag + 15'd1;
                        state <= ST_HI;
                    end
                end
                ST_HI: state <= ST_LO;
                ST_LO: begin
                    done_o <= 1'b1;
                    state  <= DONE;
                end
                DONE:    state <= DONE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_f2i_top.sv
// Bench for f2i_top: backdoor-loads operands, releases reset, and compares stored results to a real-valued model.
module tb_f2i_top;
    localparam int OP_ADDR  = 64;
    localparam int RES_ADDR = 66;

    logic       clk = 1'b0;
    logic       reset_i;
    logic       done_o;
    logic [2:0] fsm_state;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    f2i_top dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .done_o    (done_o),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    // Reference: evaluate the binary16 value as a real, then truncate (or round) and saturate.
    function automatic logic [15:0] model(input logic [15:0] h);
        int  f;
        int  m;
        real v;
        logic [15:0] r;
        f = int'(h[14:10]);
        if (f >= 30) begin
            m = 32767;
        end else begin
            if (f == 0) begin
                v = real'(h[9:0]);
                for (int i = 0; i < 24; i++) v = v / 2.0;
            end else begin
                v = real'(1024 + int'(h[9:0]));
                if (f > 25) for (int i = 0; i < f - 25; i++) v = v * 2.0;
                else        for (int i = 0; i < 25 - f; i++) v = v / 2.0;
            end
`ifdef ROUND_NEAREST_EN
            v = v + 0.5;
`endif
            if (v >= 32767.0) m = 32767;
            else              m = $rtoi(v);
        end
        r = {h[15], 15'(m)};
        return r;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [15:0] op, input logic [15:0] res, input logic [7:0] nb);
        dut.data_mem1.my_memory[OP_ADDR]    = op[15:8];
        dut.data_mem1.my_memory[OP_ADDR+1]  = op[7:0];
        dut.data_mem1.my_memory[RES_ADDR]   = res[15:8];
        dut.data_mem1.my_memory[RES_ADDR+1] = res[7:0];
        dut.data_mem1.my_memory[RES_ADDR+2] = nb;
    endtask

    function automatic logic [15:0] read_res();
        logic [15:0] r;
        r = {dut.data_mem1.my_memory[RES_ADDR], dut.data_mem1.my_memory[RES_ADDR+1]};
        return r;
    endfunction

    task automatic run_conv(input logic [15:0] op, input string tag);
        logic [15:0] exp_res;
        logic [7:0]  nb;
        logic [15:0] op_now;
        int          lat;
        exp_res = model(op);
        nb      = 8'($urandom_range(0, 255));
        @(negedge clk);
        reset_i = 1'b0;
        // Sentinel is the complement of the expected result so a missing write is visible.
        load_mem(op, ~exp_res, nb);
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        lat = 0;
        while (lat < 40 && done_o !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ":done_in_32"}, 16'(done_o === 1'b1 && lat <= 32), 16'd1);
        check({tag, ":result"}, read_res(), exp_res);
        op_now = {dut.data_mem1.my_memory[OP_ADDR], dut.data_mem1.my_memory[OP_ADDR+1]};
        check({tag, ":operand_kept"}, op_now, op);
        check({tag, ":neighbor_kept"}, 16'(dut.data_mem1.my_memory[RES_ADDR+2]), 16'(nb));
        repeat (3) @(posedge clk);
        #1;
        check({tag, ":done_held"}, {15'd0, done_o}, 16'd1);
        check({tag, ":state_done"}, {13'd0, fsm_state}, 16'd7);
    endtask

    initial begin
        logic [15:0] op;
        logic [15:0] sentinel;

        reset_i = 1'b1;
        #3 reset_i = 1'b0;
        #4;
        check("reset:done", {15'd0, done_o}, 16'd0);
        check("reset:state", {13'd0, fsm_state}, 16'd0);

        run_conv(16'h8204, "neg_subnormal");
        run_conv(16'hC204, "neg_3p0078");
        run_conv(16'hCA10, "neg_12p125");
        run_conv(16'hD20F, "neg_48p47");
        run_conv(16'h77FF, "max_finite");
        run_conv(16'h7800, "exp30_sat");
        run_conv(16'h7C00, "pos_inf");
        run_conv(16'hF800, "neg_exp30_sat");
        run_conv(16'h7E00, "nan");
        run_conv(16'h3C00, "one");
        run_conv(16'h3E00, "one_half");
        run_conv(16'h3800, "half");
        run_conv(16'h8000, "neg_zero");
        run_conv(16'h0000, "pos_zero");
        run_conv(16'h6400, "exact_1024");

        // Abort mid-conversion: result bytes must stay untouched, then a fresh run completes.
        @(negedge clk);
        reset_i  = 1'b0;
        sentinel = 16'hA55A;
        load_mem(16'h4A10, sentinel, 8'h3C);
        repeat (2) @(negedge clk);
        reset_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        #1;
        check("abort:done", {15'd0, done_o}, 16'd0);
        check("abort:result_untouched", read_res(), sentinel);
        repeat (4) @(negedge clk);
        check("abort:result_still", read_res(), sentinel);
        reset_i = 1'b1;
        for (int i = 0; i < 32 && done_o !== 1'b1; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort:rerun_done", {15'd0, done_o}, 16'd1);
        check("abort:rerun_result", read_res(), model(16'h4A10));

        for (int i = 0; i < 20; i++) begin
            op = 16'($urandom_range(0, 65535));
            run_conv(op, $sformatf("rand%0d_%h", i, op));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
